// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter that time-shares one registered logical_unit between NREQ requesters.
// The winner's operands are latched onto lu_*, and its result comes back with a done pulse.
//
// state     | meaning
// S_IDLE    | waiting; picks the next requester from ptr_q and latches its operands
// S_ISSUE   | operands held on lu_*; the shared unit samples them this cycle
// S_CAPTURE | lu_res is valid; it is registered into result with a done pulse
module logic_unit_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] op1_bus,
    input  logic [NREQ*WIDTH-1:0] op2_bus,
    input  logic [NREQ*2-1:0]     sel_bus,
    output logic [NREQ-1:0]       grant,
    output logic [NREQ-1:0]       done,
    output logic [WIDTH-1:0]      result,
    output logic                  busy,
    output logic [CNT_W-1:0]      grant_count,
    output logic [WIDTH-1:0]      lu_op1,
    output logic [WIDTH-1:0]      lu_op2,
    output logic [1:0]            lu_sel,
    input  logic [WIDTH-1:0]      lu_res
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2
    } state_t;

    state_t             state_q;
    logic [PTR_W-1:0]   ptr_q;
    logic [PTR_W-1:0]   owner_q;
    logic [NREQ-1:0]    grant_q;
    logic [NREQ-1:0]    done_q;
    logic [WIDTH-1:0]   result_q;
    logic               busy_q;
    logic [CNT_W-1:0]   count_q;
    logic [WIDTH-1:0]   lu_op1_q;
    logic [WIDTH-1:0]   lu_op2_q;
    logic [1:0]         lu_sel_q;

    logic               found_d;
    logic [PTR_W-1:0]   pick_d;
    logic [PTR_W-1:0]   ptr_d;
    logic [PTR_W:0]     idx_d;

    // Scan from the round-robin pointer, wrapping at NREQ (which need not be a power of two).
    always_comb begin
        found_d = 1'b0;
        pick_d  = '0;
        idx_d   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx_d = {1'b0, ptr_q} + (PTR_W+1)'(k);
            if (idx_d >= (PTR_W+1)'(NREQ)) begin
                idx_d = idx_d - (PTR_W+1)'(NREQ);
            end
            if (!found_d && req[idx_d[PTR_W-1:0]]) begin
                found_d = 1'b1;
                pick_d  = idx_d[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        ptr_d = '0;
        if (pick_d != PTR_W'(NREQ - 1)) begin
            ptr_d = pick_d + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            owner_q  <= '0;
            grant_q  <= '0;
            done_q   <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            count_q  <= '0;
            lu_op1_q <= '0;
            lu_op2_q <= '0;
            lu_sel_q <= '0;
        end else begin
            grant_q <= '0;
            done_q  <= '0;
            case (state_q)
                S_IDLE: begin
                    if (found_d) begin
                        owner_q         <= pick_d;
                        ptr_q           <= ptr_d;
                        grant_q[pick_d] <= 1'b1;
                        count_q         <= count_q + CNT_W'(1);
                        lu_op1_q        <= op1_bus[pick_d*WIDTH +: WIDTH];
                        lu_op2_q        <= op2_bus[pick_d*WIDTH +: WIDTH];
                        lu_sel_q        <= sel_bus[pick_d*2 +: 2];
                        busy_q          <= 1'b1;
                        state_q         <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    state_q <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    result_q        <= lu_res;
                    done_q[owner_q] <= 1'b1;
                    busy_q          <= 1'b0;
                    state_q         <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign grant       = grant_q;
    assign done        = done_q;
    assign result      = result_q;
    assign busy        = busy_q;
    assign grant_count = count_q;
    assign lu_op1      = lu_op1_q;
    assign lu_op2      = lu_op2_q;
    assign lu_sel      = lu_sel_q;

endmodule
